bv8_gamma_pipe: RTL and testbench

- Pipelined front half of the tower-field GF(2^8) inverter in the AES S-box datapath.
- Takes a byte already mapped to tower basis, split as {x_h, x_l} over GF(2^4).
- Computes Gamma = (x_h * x_l) ^ sq_scl(x_h ^ x_l) and hands Gamma, x_h and x_l to the downstream stage that feeds bv4_inv and the output multipliers.
- Uses a valid/ready handshake with full back-pressure, so it can sit in a stalling S-box lane.

---
 rtl/bv8_gamma_pipe_pkg.sv | 63 ++++++
 rtl/bv8_gamma_pipe_bv4_mul.sv | 39 +++
 rtl/bv8_gamma_pipe.sv | 156 +++++++++++++++
 tb/tb_bv8_gamma_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bv8_gamma_pipe_pkg.sv
// -----------------------------------------------------------------------------
// bv8_gamma_pipe_pkg
//   Shared GF(2^4) types, constants and helpers for the tower-field inverter
//   front half.
//   GF(2^4) is represented in polynomial basis modulo x^4 + x + 1.
//   BV4_SQ_SCL_NU = x^3 has absolute trace 1, so y^2 + y + nu is irreducible
//   over GF(2^4).
//   Contents:
//     bv4_t, bv8_t         - nibble / byte types
//     BV4_SQ_SCL_NU        - scale constant used by sq_scl
//     bv4_mul()            - GF(2^4) multiply (shift-and-add reference form)
//     bv4_sq()             - GF(2^4) square (linear, XOR only)
//     bv4_sq_scl()         - square then scale by BV4_SQ_SCL_NU
//     gamma_ref()          - golden Gamma for a tower-basis byte
//     prod_stage_t         - first-stage payload of the two-stage pipe
//     gamma_stage_t        - payload presented on the outputs
// -----------------------------------------------------------------------------
package bv8_gamma_pipe_pkg;

  typedef logic [3:0] bv4_t;
  typedef logic [7:0] bv8_t;

  localparam bv4_t BV4_SQ_SCL_NU = 4'h8;

  typedef struct packed {
    bv4_t p;
    bv4_t q;
    bv4_t h;
    bv4_t l;
  } prod_stage_t;

  typedef struct packed {
    bv4_t gamma;
    bv4_t h;
    bv4_t l;
  } gamma_stage_t;

  function automatic bv4_t bv4_mul(input bv4_t a, input bv4_t b);
    logic [6:0] p;
    p = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ (7'(a) << i);
    end
    for (int unsigned i = 6; i >= 4; i--) begin
      if (p[i]) p = p ^ (7'(5'b10011) << (i - 4));
    end
    return p[3:0];
  endfunction

  // a^2 folds x^6 -> x^3 + x^2 and x^4 -> x + 1.
  function automatic bv4_t bv4_sq(input bv4_t a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  function automatic bv4_t bv4_sq_scl(input bv4_t a);
    return bv4_mul(bv4_sq(a), BV4_SQ_SCL_NU);
  endfunction

  function automatic bv4_t gamma_ref(input bv8_t x);
    return bv4_mul(x[7:4], x[3:0]) ^ bv4_sq_scl(x[7:4] ^ x[3:0]);
  endfunction

endpackage

// File: rtl/bv8_gamma_pipe_bv4_mul.sv
// -----------------------------------------------------------------------------
// bv4_mul
//   Combinational GF(2^4) multiplier, polynomial basis mod x^4 + x + 1.
//   Flat AND/XOR network; shared by the Gamma stage and the output multipliers.
//   Ports:
//     a, b : 4-bit operands
//     p    : 4-bit product a * b
// -----------------------------------------------------------------------------
module bv4_mul
  import bv8_gamma_pipe_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  logic [6:0] c;

  always_comb begin
    c    = '0;
    c[0] = a[0] & b[0];
    c[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    c[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
    c[3] = (a[3] & b[0]) ^ (a[2] & b[1]) ^ (a[1] & b[2]) ^ (a[0] & b[3]);
    c[4] = (a[3] & b[1]) ^ (a[2] & b[2]) ^ (a[1] & b[3]);
    c[5] = (a[3] & b[2]) ^ (a[2] & b[3]);
    c[6] = a[3] & b[3];
  end

  // Reduce: x^4 = x + 1, x^5 = x^2 + x, x^6 = x^3 + x^2.
  always_comb begin
    p    = '0;
    p[0] = c[0] ^ c[4];
    p[1] = c[1] ^ c[4] ^ c[5];
    p[2] = c[2] ^ c[5] ^ c[6];
    p[3] = c[3] ^ c[6];
  end

endmodule

// File: rtl/bv8_gamma_pipe.sv
// -----------------------------------------------------------------------------
// bv8_gamma_pipe
//   Front half of the tower-field GF(2^8) inverter:
//     Gamma = (x_h * x_l) ^ sq_scl(x_h ^ x_l)
//   Valid/ready pipeline with full back-pressure, PIPE_STAGES = 1 or 2.
//   Optional build macro GAMMA_ZERO_FLAG_EN adds out_zero (accepted byte
//   was 0x00), pipelined alongside the data.
//   Ports:
//     in_clock   - rising-edge clock
//     in_reset   - asynchronous active-high reset
//     in_valid   - upstream byte valid
//     out_ready  - block accepts in_x this cycle (combinational from in_ready)
//     in_x       - tower-basis byte, [7:4] = x_h, [3:0] = x_l
//     out_valid  - out_gamma/out_h/out_l valid
//     in_ready   - downstream accepts this cycle
//     out_gamma  - Gamma for bv4_inv
//     out_h      - x_h aligned with out_gamma
//     out_l      - x_l aligned with out_gamma
//     out_zero   - (GAMMA_ZERO_FLAG_EN only) accepted byte was 0x00
// -----------------------------------------------------------------------------
module bv8_gamma_pipe
  import bv8_gamma_pipe_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2
)
(
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic [7:0] in_x,
  output logic       out_valid,
  input  logic       in_ready,
  output logic [3:0] out_gamma,
  output logic [3:0] out_h,
  output logic [3:0] out_l
`ifdef GAMMA_ZERO_FLAG_EN
  ,
  output logic       out_zero
`endif
);

  bv4_t x_h;
  bv4_t x_l;
  bv4_t prod;
  bv4_t sq_q;

  assign x_h = in_x[7:4];
  assign x_l = in_x[3:0];

  bv4_mul u_mul (
    .a (x_h),
    .b (x_l),
    .p (prod)
  );

  always_comb begin
    sq_q = bv4_sq_scl(x_h ^ x_l);
  end

`ifdef GAMMA_ZERO_FLAG_EN
  logic x_zero;
  assign x_zero = (in_x == 8'h00);
`endif

  if (PIPE_STAGES == 1) begin : g_one_stage

    logic         s_v;
    gamma_stage_t s_d;
    logic         s_adv;

    assign s_adv = ~s_v | in_ready;

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        s_v <= 1'b0;
        s_d <= '0;
      end else if (s_adv) begin
        s_v <= in_valid;
        if (in_valid) s_d <= '{gamma: prod ^ sq_q, h: x_h, l: x_l};
      end
    end

    assign out_ready = s_adv;
    assign out_valid = s_v;
    assign out_gamma = s_d.gamma;
    assign out_h     = s_d.h;
    assign out_l     = s_d.l;

`ifdef GAMMA_ZERO_FLAG_EN
    logic s_z;
    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) s_z <= 1'b0;
      else if (s_adv && in_valid) s_z <= x_zero;
    end
    assign out_zero = s_z;
`endif

  end else begin : g_two_stage

    logic         v1;
    logic         v2;
    prod_stage_t  d1;
    gamma_stage_t d2;
    logic         adv1;
    logic         adv2;

    // Ready ripples back combinationally so a full pipe can still take a
    // byte in the same cycle the output is consumed.
    assign adv2 = ~v2 | in_ready;
    assign adv1 = ~v1 | adv2;

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else if (adv1) begin
        v1 <= in_valid;
        if (in_valid) d1 <= '{p: prod, q: sq_q, h: x_h, l: x_l};
      end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (adv2) begin
        v2 <= v1;
        if (v1) d2 <= '{gamma: d1.p ^ d1.q, h: d1.h, l: d1.l};
      end
    end

    assign out_ready = adv1;
    assign out_valid = v2;
    assign out_gamma = d2.gamma;
    assign out_h     = d2.h;
    assign out_l     = d2.l;

`ifdef GAMMA_ZERO_FLAG_EN
    logic z1;
    logic z2;
    always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
        z1 <= 1'b0;
        z2 <= 1'b0;
      end else begin
        if (adv1 && in_valid) z1 <= x_zero;
        if (adv2 && v1)       z2 <= z1;
      end
    end
    assign out_zero = z2;
`endif

  end

endmodule

// File: tb/tb_bv8_gamma_pipe.sv
module tb_bv8_gamma_pipe;
  import bv8_gamma_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Two-stage instance (default parameter)
  logic       in_valid = 1'b0;
  logic [7:0] in_x     = 8'h00;
  logic       in_ready = 1'b1;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_gamma;
  logic [3:0] out_h;
  logic [3:0] out_l;

  // Single-stage instance
  logic       v1_in = 1'b0;
  logic [7:0] x1_in = 8'h00;
  logic       r1_in = 1'b1;
  logic       ready1_out;
  logic       valid1_out;
  logic [3:0] g1_out;
  logic [3:0] h1_out;
  logic [3:0] l1_out;
`ifdef GAMMA_ZERO_FLAG_EN
  logic       z_out;
  logic       z1_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;
  int cyc      = 0;
  int out_mark = 0;
  int first_out_cyc = 0;
  int last_out_cyc  = 0;
  bv8_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bv8_gamma_pipe #(.PIPE_STAGES(2)) u_dut (
    .in_clock  (clk),
    .in_reset  (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_gamma (out_gamma),
    .out_h     (out_h),
    .out_l     (out_l)
`ifdef GAMMA_ZERO_FLAG_EN
    ,
    .out_zero  (z_out)
`endif
  );

  bv8_gamma_pipe #(.PIPE_STAGES(1)) u_dut1 (
    .in_clock  (clk),
    .in_reset  (rst),
    .in_valid  (v1_in),
    .out_ready (ready1_out),
    .in_x      (x1_in),
    .out_valid (valid1_out),
    .in_ready  (r1_in),
    .out_gamma (g1_out),
    .out_h     (h1_out),
    .out_l     (l1_out)
`ifdef GAMMA_ZERO_FLAG_EN
    ,
    .out_zero  (z1_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard on the two-stage instance; sampled mid-cycle.
  always @(negedge clk) begin
    bv8_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && in_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_gamma", 32'(out_gamma), 32'(gamma_ref(e)));
          check("sb_h", 32'(out_h), 32'(e[7:4]));
          check("sb_l", 32'(out_l), 32'(e[3:0]));
          if (n_out == out_mark) first_out_cyc = cyc;
          last_out_cyc = cyc;
          n_out++;
        end
      end
      if (in_valid && out_ready) begin
        sb.push_back(in_x);
        n_in++;
      end
    end
  end

  // Hand-computed Gamma values (GF(2^4) mod x^4+x+1, nu = x^3)
  bv8_t hv_x [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h53, 8'hFF, 8'h12};
  bv4_t hv_g [9] = '{4'h0, 4'h8, 4'h6, 4'hE, 4'h8, 4'h1, 4'h2, 4'hA, 4'hC};

  initial begin
    int snap_in;
    int snap_out;
    int stalls;

    // ---- reset state ----
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gamma", 32'(out_gamma), 32'd0);
    check("rst_h", 32'(out_h), 32'd0);
    check("rst_l", 32'(out_l), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("post_rst_ready", 32'(out_ready), 32'd1);

    // ---- single byte 0x00, latency 2 ----
    in_valid = 1'b1; in_x = 8'h00; in_ready = 1'b1;
    #1 check("lat_c0_valid", 32'(out_valid), 32'd0);
    step(); in_valid = 1'b0;
    #1 check("lat_c1_valid", 32'(out_valid), 32'd0);
    step();
    #1 check("lat_c2_valid", 32'(out_valid), 32'd1);
    check("zero_gamma", 32'(out_gamma), 32'd0);
    check("zero_h", 32'(out_h), 32'd0);
    check("zero_l", 32'(out_l), 32'd0);
    step();
    #1 check("lat_c3_valid", 32'(out_valid), 32'd0);

    // ---- directed hand vectors ----
    for (int i = 0; i < 9; i++) begin
      step(); in_valid = 1'b1; in_x = hv_x[i];
      step(); in_valid = 1'b0;
      step();
      #1 check("hv_valid", 32'(out_valid), 32'd1);
      check($sformatf("hv_gamma_%02h", hv_x[i]), 32'(out_gamma), 32'(hv_g[i]));
      check("hv_h", 32'(out_h), 32'(hv_x[i][7:4]));
      check("hv_l", 32'(out_l), 32'(hv_x[i][3:0]));
    end
    step(); step();

    // ---- streaming all 256 bytes ----
    out_mark = n_out;
    snap_in  = n_in;
    stalls   = 0;
    for (int i = 0; i < 256; i++) begin
      step(); in_valid = 1'b1; in_x = 8'(i);
      #1 if (!out_ready) stalls++;
    end
    step(); in_valid = 1'b0;
    repeat (5) step();
    check("stream_stalls", 32'(stalls), 32'd0);
    check("stream_in", 32'(n_in - snap_in), 32'd256);
    check("stream_out", 32'(n_out - out_mark), 32'd256);
    check("stream_span", 32'(last_out_cyc - first_out_cyc), 32'd255);

    // ---- back-pressure ----
    snap_in = n_in; snap_out = n_out;
    step(); in_ready = 1'b0; in_valid = 1'b1; in_x = 8'h01;
    #1 check("bp_ready0", 32'(out_ready), 32'd1);
    step(); in_x = 8'h02;
    #1 check("bp_ready1", 32'(out_ready), 32'd1);
    step(); in_x = 8'h03;
    #1 check("bp_full_ready", 32'(out_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_gamma", 32'(out_gamma), 32'h8);
    check("bp_l", 32'(out_l), 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      #1 check("bp_hold_gamma", 32'(out_gamma), 32'h8);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(out_ready), 32'd0);
    end
    step(); in_ready = 1'b1;
    #1 check("bp_ready_comb", 32'(out_ready), 32'd1);
    step(); in_valid = 1'b0;
    repeat (4) step();
    check("bp_in", 32'(n_in - snap_in), 32'd3);
    check("bp_out", 32'(n_out - snap_out), 32'd3);

    // ---- full pipe, simultaneous in/out ----
    step(); in_ready = 1'b0; in_valid = 1'b1; in_x = 8'h20;
    step(); in_x = 8'h21;
    step(); in_valid = 1'b0;
    snap_in = n_in; snap_out = n_out;
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      step(); in_valid = 1'b1; in_ready = 1'b1; in_x = 8'(8'h22 + k);
      #1 if (!out_ready || !out_valid) stalls++;
    end
    step(); in_valid = 1'b0;
    check("full_bubbles", 32'(stalls), 32'd0);
    check("full_in", 32'(n_in - snap_in), 32'd10);
    check("full_out", 32'(n_out - snap_out), 32'd10);
    repeat (4) step();

    // ---- reset mid-stream ----
    step(); in_ready = 1'b0; in_valid = 1'b1; in_x = 8'h40;
    step(); in_x = 8'h41;
    step(); in_valid = 1'b0;
    #1 check("mr_pre_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1 check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_gamma", 32'(out_gamma), 32'd0);
    check("mr_h", 32'(out_h), 32'd0);
    check("mr_l", 32'(out_l), 32'd0);
    step(); rst = 1'b0;
    step(); in_ready = 1'b1; in_valid = 1'b1; in_x = 8'h53;
    step(); in_valid = 1'b0;
    #1 check("mr_c1_valid", 32'(out_valid), 32'd0);
    step();
    #1 check("mr_first_valid", 32'(out_valid), 32'd1);
    check("mr_first_gamma", 32'(out_gamma), 32'h2);
    check("mr_first_h", 32'(out_h), 32'h5);
    check("mr_first_l", 32'(out_l), 32'h3);
    repeat (3) step();

    // ---- single-stage instance: 0x00 then 0x53 ----
    v1_in = 1'b1; x1_in = 8'h00; r1_in = 1'b1;
    #1 check("s1_c0_valid", 32'(valid1_out), 32'd0);
    step(); x1_in = 8'h53;
    #1 check("s1_c1_valid", 32'(valid1_out), 32'd1);
    check("s1_gamma0", 32'(g1_out), 32'h0);
    check("s1_h0", 32'(h1_out), 32'h0);
`ifdef GAMMA_ZERO_FLAG_EN
    check("s1_zero1", 32'(z1_out), 32'd1);
`endif
    step(); v1_in = 1'b0;
    #1 check("s1_c2_valid", 32'(valid1_out), 32'd1);
    check("s1_gamma53", 32'(g1_out), 32'h2);
    check("s1_h53", 32'(h1_out), 32'h5);
    check("s1_l53", 32'(l1_out), 32'h3);
`ifdef GAMMA_ZERO_FLAG_EN
    check("s1_zero0", 32'(z1_out), 32'd0);
`endif
    step();
    #1 check("s1_c3_valid", 32'(valid1_out), 32'd0);

    // single-stage back-pressure: full after one accept
    step(); r1_in = 1'b0; v1_in = 1'b1; x1_in = 8'h12;
    #1 check("s1_bp_ready0", 32'(ready1_out), 32'd1);
    step(); x1_in = 8'h13;
    #1 check("s1_bp_ready1", 32'(ready1_out), 32'd0);
    check("s1_bp_gamma", 32'(g1_out), 32'hC);
    step();
    #1 check("s1_bp_hold", 32'(g1_out), 32'hC);
    r1_in = 1'b1;
    #1 check("s1_bp_ready_comb", 32'(ready1_out), 32'd1);
    step(); v1_in = 1'b0;
    #1 check("s1_bp_next_l", 32'(l1_out), 32'h3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
